// File: rtl/sc_win_level_controller.sv
// sc_win_level_controller: level/win sequencing FSM (IDLE, PLAY, WIN_HOLD, DONE) with registered outputs.
// Ports: CLOCK_50 clock, RESET_InLow sync active-low reset, win_InBUS comparator code,
// frameTick_In frame pulse, start_In start pulse; state_OutBUS, level_OutBUS, loadLast_Out,
// clearBoard_Out, winFlag_Out, gameDone_Out.
// Macro SC_WIN_LEVEL_CONTROLLER_WIN_DEBOUNCE_EN: code 00 qualifies only after 3 consecutive PLAY cycles.
module sc_win_level_controller #(
  parameter int HOLD_FRAMES = 60,
  parameter int LEVEL_WIDTH = 4,
  parameter int MAX_LEVEL   = 9
) (
  input  logic                   sc_win_level_controller_CLOCK_50,
  input  logic                   sc_win_level_controller_RESET_InLow,
  input  logic [1:0]             sc_win_level_controller_win_InBUS,
  input  logic                   sc_win_level_controller_frameTick_In,
  input  logic                   sc_win_level_controller_start_In,
  output logic [1:0]             sc_win_level_controller_state_OutBUS,
  output logic [LEVEL_WIDTH-1:0] sc_win_level_controller_level_OutBUS,
  output logic                   sc_win_level_controller_loadLast_Out,
  output logic                   sc_win_level_controller_clearBoard_Out,
  output logic                   sc_win_level_controller_winFlag_Out,
  output logic                   sc_win_level_controller_gameDone_Out
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WIN_HOLD = 2'b10, DONE = 2'b11} state_t;
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(MAX_LEVEL);
  logic clk, rst_n, tick, start;
  logic [1:0] win;
  state_t state_q, state_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [7:0] hold_q, hold_d;
  logic load_last_q, load_last_d, clear_board_q, clear_board_d;
  logic win_flag_q, win_flag_d, game_done_q, game_done_d;
  logic win_ok;
  assign clk   = sc_win_level_controller_CLOCK_50;
  assign rst_n = sc_win_level_controller_RESET_InLow;
  assign win   = sc_win_level_controller_win_InBUS;
  assign tick  = sc_win_level_controller_frameTick_In;
  assign start = sc_win_level_controller_start_In;
`ifdef SC_WIN_LEVEL_CONTROLLER_WIN_DEBOUNCE_EN
  logic [1:0] run_q, run_d;
  // run_q counts prior consecutive 00 cycles in PLAY; it is zero on the PLAY-entry cycle
  assign run_d  = (state_q == PLAY && win == 2'b00) ? run_q + 2'd1 : 2'd0;
  assign win_ok = win == 2'b00 && run_q == 2'd2;
  always_ff @(posedge clk) run_q <= !rst_n ? 2'd0 : run_d;
`else
  assign win_ok = win == 2'b00;
`endif
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    hold_d        = hold_q;
    load_last_d   = 1'b0;
    clear_board_d = 1'b0;
    win_flag_d    = win_flag_q;
    game_done_d   = game_done_q;
    case (state_q)
      IDLE: if (start) begin
        state_d       = PLAY;
        level_d       = '0;
        clear_board_d = 1'b1;
      end
      PLAY: begin
        load_last_d = win == 2'b10;
        if (win_ok) begin
          state_d    = WIN_HOLD;
          hold_d     = HOLD_INIT;
          win_flag_d = 1'b1;
        end
      end
      WIN_HOLD: if (tick) begin
        if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
        else if (level_q < LEVEL_MAX) begin
          state_d       = PLAY;
          level_d       = level_q + 1'b1;
          clear_board_d = 1'b1;
          win_flag_d    = 1'b0;
        end else begin
          state_d     = DONE;
          game_done_d = 1'b1;
          win_flag_d  = 1'b0;
        end
      end
      DONE: if (start) begin
        state_d       = PLAY;
        level_d       = '0;
        game_done_d   = 1'b0;
        clear_board_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      level_q       <= '0;
      hold_q        <= '0;
      load_last_q   <= 1'b0;
      clear_board_q <= 1'b0;
      win_flag_q    <= 1'b0;
      game_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      hold_q        <= hold_d;
      load_last_q   <= load_last_d & ~clear_board_d;
      clear_board_q <= clear_board_d;
      win_flag_q    <= win_flag_d;
      game_done_q   <= game_done_d;
    end
  end
  assign sc_win_level_controller_state_OutBUS   = state_q;
  assign sc_win_level_controller_level_OutBUS   = level_q;
  assign sc_win_level_controller_loadLast_Out   = load_last_q;
  assign sc_win_level_controller_clearBoard_Out = clear_board_q;
  assign sc_win_level_controller_winFlag_Out    = win_flag_q;
  assign sc_win_level_controller_gameDone_Out   = game_done_q;
endmodule

// File: tb/tb_sc_win_level_controller.sv
// tb_sc_win_level_controller: vector table, corner sequences and randomized model check for sc_win_level_controller.
module tb_sc_win_level_controller;
  localparam int HOLD = 3;
  localparam int MAXL = 2;
`ifdef SC_WIN_LEVEL_CONTROLLER_WIN_DEBOUNCE_EN
  localparam int NEED = 3;
`else
  localparam int NEED = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
  logic [1:0] win = 2'b11;
  logic [1:0] st;
  logic [3:0] lvl;
  logic ld, clr, wf, gd;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_level = 0, m_left = 0, m_streak = 0;
  bit m_ld, m_clr, m_wf, m_gd;
  always #5 clk = ~clk;
  sc_win_level_controller #(.HOLD_FRAMES(HOLD), .LEVEL_WIDTH(4), .MAX_LEVEL(MAXL)) dut (
    .sc_win_level_controller_CLOCK_50(clk),
    .sc_win_level_controller_RESET_InLow(rst_n),
    .sc_win_level_controller_win_InBUS(win),
    .sc_win_level_controller_frameTick_In(tick),
    .sc_win_level_controller_start_In(start),
    .sc_win_level_controller_state_OutBUS(st),
    .sc_win_level_controller_level_OutBUS(lvl),
    .sc_win_level_controller_loadLast_Out(ld),
    .sc_win_level_controller_clearBoard_Out(clr),
    .sc_win_level_controller_winFlag_Out(wf),
    .sc_win_level_controller_gameDone_Out(gd)
  );
  typedef struct {
    bit r; bit [1:0] w; bit t; bit s;
    bit [1:0] e_st; int e_lvl; bit e_ld, e_clr, e_wf, e_gd;
  } vec_t;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Game rules: frames are counted down from HOLD, a win needs NEED consecutive 00 codes while playing.
  task automatic model(input bit r, input bit [1:0] w, input bit t, input bit s);
    m_ld = 0;
    m_clr = 0;
    if (!r) begin
      m_mode = 0; m_level = 0; m_left = 0; m_wf = 0; m_gd = 0; m_streak = 0;
    end else if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_level = 0; m_clr = 1; m_streak = 0; end
    end else if (m_mode == 1) begin
      m_ld = (w == 2'b10);
      m_streak = (w == 2'b00) ? m_streak + 1 : 0;
      if (m_streak >= NEED) begin m_mode = 2; m_left = HOLD; m_wf = 1; m_streak = 0; end
    end else if (m_mode == 2) begin
      if (t) begin
        m_left--;
        if (m_left == 0) begin
          m_wf = 0;
          if (m_level < MAXL) begin m_level++; m_clr = 1; m_mode = 1; m_streak = 0; end
          else begin m_mode = 3; m_gd = 1; end
        end
      end
    end else if (s) begin
      m_mode = 1; m_level = 0; m_gd = 0; m_clr = 1; m_streak = 0;
    end
  endtask
  task automatic apply(input bit r, input bit [1:0] w, input bit t, input bit s);
    @(negedge clk);
    rst_n = r; win = w; tick = t; start = s;
    @(posedge clk);
    model(r, w, t, s);
    #1;
  endtask
  task automatic check_model(input string tag);
    check({tag, ".state"}, int'(st), m_mode);
    check({tag, ".level"}, int'(lvl), m_level);
    check({tag, ".loadLast"}, int'(ld), int'(m_ld));
    check({tag, ".clearBoard"}, int'(clr), int'(m_clr));
    check({tag, ".winFlag"}, int'(wf), int'(m_wf));
    check({tag, ".gameDone"}, int'(gd), int'(m_gd));
  endtask
  initial begin
    vec_t v[$];
    v.push_back('{0, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0});
    v.push_back('{1, 2'b11, 0, 0, 2'b00, 0, 0, 0, 0, 0});
    v.push_back('{1, 2'b00, 0, 1, 2'b01, 0, 0, 1, 0, 0});
    v.push_back('{1, 2'b11, 0, 0, 2'b01, 0, 0, 0, 0, 0});
    v.push_back('{1, 2'b10, 0, 0, 2'b01, 0, 1, 0, 0, 0});
    v.push_back('{1, 2'b10, 0, 0, 2'b01, 0, 1, 0, 0, 0});
    v.push_back('{1, 2'b11, 0, 0, 2'b01, 0, 0, 0, 0, 0});
    v.push_back('{1, 2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 0});
    v.push_back('{1, 2'b00, 0, 0, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 0, 1, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{1, 2'b10, 1, 0, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 0, 0, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{1, 2'b00, 1, 0, 2'b01, 1, 0, 1, 0, 0});
    v.push_back('{1, 2'b00, 0, 0, 2'b10, 1, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b10, 1, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b10, 1, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b01, 2, 0, 1, 0, 0});
    v.push_back('{1, 2'b00, 0, 0, 2'b10, 2, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b10, 2, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b10, 2, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b11, 2, 0, 0, 0, 1});
    v.push_back('{1, 2'b00, 1, 0, 2'b11, 2, 0, 0, 0, 1});
    v.push_back('{1, 2'b11, 0, 1, 2'b01, 0, 0, 1, 0, 0});
    v.push_back('{1, 2'b00, 0, 0, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{1, 2'b11, 1, 0, 2'b10, 0, 0, 0, 1, 0});
    v.push_back('{0, 2'b00, 1, 1, 2'b00, 0, 0, 0, 0, 0});
    v.push_back('{1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0});
`ifndef SC_WIN_LEVEL_CONTROLLER_WIN_DEBOUNCE_EN
    foreach (v[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(v[i].r, v[i].w, v[i].t, v[i].s);
      check({tag, ".state"}, int'(st), int'(v[i].e_st));
      check({tag, ".level"}, int'(lvl), v[i].e_lvl);
      check({tag, ".loadLast"}, int'(ld), int'(v[i].e_ld));
      check({tag, ".clearBoard"}, int'(clr), int'(v[i].e_clr));
      check({tag, ".winFlag"}, int'(wf), int'(v[i].e_wf));
      check({tag, ".gameDone"}, int'(gd), int'(v[i].e_gd));
    end
`else
    begin
      bit [1:0] seq [6];
      seq = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
      apply(0, 2'b11, 0, 0);
      apply(1, 2'b11, 0, 1);
      check("deb.entry", int'(st), 1);
      for (int i = 0; i < 6; i++) begin
        apply(1, seq[i], 0, 0);
        check($sformatf("deb.step%0d", i), int'(st), i == 5 ? 2 : 1);
        check($sformatf("deb.flag%0d", i), int'(wf), i == 5 ? 1 : 0);
      end
      check_model("deb");
    end
`endif
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(39) != 0, 2'($urandom), $urandom_range(2) == 0, $urandom_range(7) == 0);
      check_model($sformatf("rnd%0d", i));
      n_cmp++;
      if (ld && clr) begin
        n_bad++;
        $display("FAIL rnd%0d.exclusive: loadLast=%0d clearBoard=%0d required not both 1", i, ld, clr);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
